// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: control codes, EX-unit state encoding and a counter sizing helper.
package alu_defs_pkg;

    localparam logic [2:0] ALUCTRL_AND = 3'b000;
    localparam logic [2:0] ALUCTRL_OR  = 3'b001;
    localparam logic [2:0] ALUCTRL_ADD = 3'b010;
    localparam logic [2:0] ALUCTRL_SUB = 3'b110;
    localparam logic [2:0] ALUCTRL_MUL = 3'b111;
    localparam logic [2:0] ALUCTRL_NOP = 3'b011;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exec_state_e;

    function automatic int unsigned cnt_bits(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/alu_multicycle_exec_if.sv
// Op/result bundle between the ID/EX pipeline register side and the EX execution unit.
interface alu_multicycle_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;

    modport master (
        output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
        input  ready_o, valid_o, data_o, zero_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
        output ready_o, valid_o, data_o, zero_o
    );
endinterface

// File: rtl/alu_multicycle_exec_mul_iter.sv
// Iterative shift-add multiplier datapath; one multiplier bit per step.
// MUL_EARLY_TERM_EN: also signal done once the remaining multiplier bits are all zero.
module mul_iter
    import alu_defs_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic [WIDTH-1:0] o_acc_next,
    output logic             o_done
);
    localparam int unsigned CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last     = (r_cnt == LAST_CNT);

`ifdef MUL_EARLY_TERM_EN
    // Done on the step that shifts out the last set multiplier bit.
    assign o_done = w_last || ((r_mplier >> 1) == '0);
`else
    assign o_done = w_last;
`endif

    assign o_acc_next = w_acc_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multicycle_exec.sv
// EX-stage unit: single-cycle add/sub/and/or/nop plus a multi-cycle multiply that stalls upstream.
// Optional MUL_EARLY_TERM_EN shortens multiply latency (handled in mul_iter).
module alu_multicycle_exec
    import alu_defs_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    alu_multicycle_exec_if.slave  bus
);
    exec_state_e      r_state;
    exec_state_e      w_state_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             w_valid_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_zero_nxt;
    logic [WIDTH-1:0] w_alu;
    logic             w_start;
    logic             w_step;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_done;

    always_comb begin
        w_alu = '0;
        case (bus.ALUCtrl_i)
            ALUCTRL_ADD: w_alu = bus.data1_i + bus.data2_i;
            ALUCTRL_SUB: w_alu = bus.data1_i - bus.data2_i;
            ALUCTRL_AND: w_alu = bus.data1_i & bus.data2_i;
            ALUCTRL_OR:  w_alu = bus.data1_i | bus.data2_i;
            default:     w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_zero_nxt  = r_zero;
        w_start     = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.valid_i && !bus.flush_i) begin
                    if (bus.ALUCtrl_i == ALUCTRL_MUL) begin
                        w_start     = 1'b1;
                        w_state_nxt = MUL;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_alu;
                        w_zero_nxt  = (w_alu == '0);
                    end
                end
            end
            MUL: begin
                // Flush drops the product even on its final iteration.
                if (bus.flush_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_done) begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_acc_next;
                        w_zero_nxt  = (w_acc_next == '0);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_start    (w_start),
        .i_step     (w_step),
        .i_mcand    (bus.data1_i),
        .i_mplier   (bus.data2_i),
        .o_acc_next (w_acc_next),
        .o_done     (w_done)
    );

    assign bus.ready_o = (r_state == IDLE);
    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;
    assign bus.zero_o  = r_zero;

endmodule
